memory_game_core: RTL and testbench

Parametrised sequence-memory game engine for the lab board. It flashes a growing pseudo-random sequence on `NUM_CH` LEDs, then checks the player's button presses against it, advancing a level on success and ending the game on a mistake. It sits between the board button/LED pins and the seven-segment driver, and signals game end to the END screen logic. Unlike the fixed 7-step version, it supports configurable channel count, sequence depth and step rate, appends one step per level, and detects a win.

---
 rtl/memory_game_core.sv | 191 +++++++++++++++++++
 tb/tb_memory_game_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_core.sv
// Sequence-memory game engine: flashes a growing LFSR-derived sequence on NUM_CH LEDs and checks the player's presses.
// Optional macro INPUT_TIMEOUT_EN adds an idle timeout in the input phase.
module memory_game_core #(
    parameter int          NUM_CH        = 4,
    parameter int          MAX_LEN       = 16,
    parameter int          TICK_DIV      = 1000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          TIMEOUT_TICKS = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_CH-1:0] btn,
    output logic [NUM_CH-1:0] led,
    output logic [7:0]        level,
    output logic [7:0]        disp_code,
    output logic              game_over,
    output logic              game_won
);
    localparam int CW  = $clog2(NUM_CH);
    localparam int AW  = $clog2(MAX_LEN);
    localparam int TDW = $clog2(TICK_DIV);
    localparam logic [TDW-1:0] TD_MAX = TDW'(TICK_DIV - 1);

    if (NUM_CH < 2 || NUM_CH > 16 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_ch
        $error("NUM_CH must be a power of two in 2..16");
    end
    if (MAX_LEN < 2 || MAX_LEN > 255) begin : g_bad_len
        $error("MAX_LEN must be in 2..255");
    end
    if (TICK_DIV < 2 || TIMEOUT_TICKS < 1 || LFSR_SEED == 16'h0) begin : g_bad_misc
        $error("TICK_DIV >= 2, TIMEOUT_TICKS >= 1, LFSR_SEED nonzero required");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_GOOD, S_END, S_WIN
    } state_t;

    state_t            state, nstate;
    logic [7:0]        idx, n_idx, n_level;
    logic [15:0]       lfsr;
    logic [TDW-1:0]    cnt;
    logic              tick, enter, half, n_half;
    logic [NUM_CH-1:0] btn_q, rise, want_oh, show_oh, n_led;
    logic [7:0]        n_disp;
    logic [CW-1:0]     seq [MAX_LEN];
    logic [CW-1:0]     cur_ch, show_ch, wdata;
    logic [AW-1:0]     waddr;
    logic              seq_we;
`ifdef INPUT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0]     to_cnt, n_to;
`endif

    assign tick   = (cnt == '0);
    assign rise   = btn & ~btn_q;
    assign cur_ch = seq[idx[AW-1:0]];
    assign wdata  = lfsr[CW-1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
        assign want_oh[g] = (cur_ch == CW'(g));
        assign show_oh[g] = (show_ch == CW'(g));
    end

    always_comb begin
        nstate  = state;
        n_level = level;
        n_idx   = idx;
        n_half  = half;
        seq_we  = 1'b0;
        waddr   = level[AW-1:0];
`ifdef INPUT_TIMEOUT_EN
        n_to    = to_cnt;
`endif
        unique case (state)
            S_IDLE, S_END, S_WIN: begin
                if (start) begin
                    nstate  = S_SHOW_ON;
                    n_level = 8'd1;
                    n_idx   = 8'd0;
                    seq_we  = 1'b1;
                    waddr   = '0;
                end
            end
            S_SHOW_ON: if (tick) nstate = S_SHOW_OFF;
            S_SHOW_OFF: begin
                if (tick) begin
                    if (idx == level - 8'd1) begin
                        nstate = S_INPUT;
                        n_idx  = 8'd0;
                    end else begin
                        nstate = S_SHOW_ON;
                        n_idx  = idx + 8'd1;
                    end
                end
            end
            S_INPUT: begin
                if (rise != '0) begin
                    // exact match implies a single rising bit on the right channel
                    if (rise == want_oh) begin
                        if (idx == level - 8'd1) nstate = S_GOOD;
                        else n_idx = idx + 8'd1;
`ifdef INPUT_TIMEOUT_EN
                        n_to = '0;
`endif
                    end else begin
                        nstate = S_END;
                    end
                end
`ifdef INPUT_TIMEOUT_EN
                else if (tick) begin
                    if (to_cnt == TW'(TIMEOUT_TICKS - 1)) nstate = S_END;
                    else n_to = to_cnt + 1'b1;
                end
`endif
            end
            S_GOOD: begin
                if (tick) begin
                    if (!half) begin
                        n_half = 1'b1;
                    end else if (level == 8'(MAX_LEN)) begin
                        nstate = S_WIN;
                    end else begin
                        nstate  = S_SHOW_ON;
                        n_level = level + 8'd1;
                        n_idx   = 8'd0;
                        seq_we  = 1'b1;
                    end
                end
            end
            default: nstate = S_IDLE;
        endcase

        enter = (nstate != state);
        if (enter) begin
            n_half = 1'b0;
`ifdef INPUT_TIMEOUT_EN
            n_to   = '0;
`endif
        end

        // bypass the entry being written this cycle so the first flash is correct
        show_ch = (seq_we && waddr == n_idx[AW-1:0]) ? wdata : seq[n_idx[AW-1:0]];
        n_led   = (nstate == S_SHOW_ON) ? show_oh : '0;
        unique case (nstate)
            S_SHOW_ON, S_SHOW_OFF, S_INPUT: n_disp = n_level;
            S_GOOD:  n_disp = 8'd255;
            S_WIN:   n_disp = 8'd254;
            S_END:   n_disp = 8'd253;
            default: n_disp = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            level     <= 8'd0;
            idx       <= 8'd0;
            half      <= 1'b0;
            lfsr      <= LFSR_SEED;
            cnt       <= TD_MAX;
            btn_q     <= '0;
            led       <= '0;
            disp_code <= 8'd0;
            game_over <= 1'b0;
            game_won  <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            state     <= nstate;
            level     <= n_level;
            idx       <= n_idx;
            half      <= n_half;
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cnt       <= (enter || tick) ? TD_MAX : cnt - 1'b1;
            btn_q     <= btn;
            led       <= n_led;
            disp_code <= n_disp;
            game_over <= (nstate == S_END);
            game_won  <= (nstate == S_WIN);
`ifdef INPUT_TIMEOUT_EN
            to_cnt    <= n_to;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && seq_we) seq[waddr] <= wdata;
    end
endmodule

// File: tb/tb_memory_game_core.sv
// Scoreboard bench for memory_game_core: stimulus pushes expected flashes/display codes, a monitor pops on each change.
module tb_memory_game_core;
    localparam int MAXL = 3;
`ifdef INPUT_TIMEOUT_EN
    localparam int HOLD = 12;
`else
    localparam int HOLD = 20;
`endif

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [3:0] btn = 4'b0, led;
    logic [7:0] level, disp_code;
    logic       game_over, game_won;

    memory_game_core #(.NUM_CH(4), .MAX_LEN(MAXL), .TICK_DIV(4), .LFSR_SEED(16'hACE1), .TIMEOUT_TICKS(5)) dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn), .led(led), .level(level),
        .disp_code(disp_code), .game_over(game_over), .game_won(game_won));

    always #5 clk = ~clk;

    // reference LFSR; m_prev is the value the DUT consumed at the most recent edge
    logic [15:0] m, m_prev;
    function automatic logic [15:0] lf_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction
    always @(posedge clk) begin
        m_prev <= m;
        m      <= reset ? 16'hACE1 : lf_next(m);
    end

    int n_cmp = 0, n_fail = 0;
    logic [31:0] exp_led[$], exp_disp[$];
    logic [1:0]  seqm [MAXL];
    logic        mon_en = 1'b0;
    logic [3:0]  prev_led = 4'b0;
    logic [7:0]  prev_disp = 8'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] oh(input logic [1:0] c);
        return 32'(4'b1 << c);
    endfunction

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            if (led != 4'b0 && prev_led == 4'b0) begin
                if (exp_led.size() == 0) check("unexpected_led", 32'(led), 32'd0);
                else check("led_step", 32'(led), exp_led.pop_front());
            end
            if (disp_code != prev_disp) begin
                if (exp_disp.size() == 0) check("unexpected_disp", 32'(disp_code), 32'(prev_disp));
                else check("disp_code", 32'(disp_code), exp_disp.pop_front());
            end
        end
        prev_led  = led;
        prev_disp = disp_code;
    end

    task automatic push_level(input int L);
        for (int i = 0; i < L; i++) exp_led.push_back(oh(seqm[i]));
        exp_disp.push_back(32'(L));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seqm[0] = m_prev[1:0];
        push_level(1);
    endtask

    task automatic show(input int L);
        repeat (8 * L) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] ch, input bit last);
        if (last) exp_disp.push_back(32'd255);
        btn = 4'(oh(ch));
        @(negedge clk);
        btn = 4'b0;
        if (!last) @(negedge clk);
    endtask

    task automatic good(input int L);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("good_disp", 32'(disp_code), 32'd255);
        end
        @(negedge clk);
        if (L == MAXL) exp_disp.push_back(32'd254);
        else begin
            seqm[L] = m_prev[1:0];
            push_level(L + 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] w;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_disp", 32'(disp_code), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        check("rst_won", 32'(game_won), 32'd0);
        mon_en = 1'b1;

        // full game to WIN
        do_start();
        check("start_level", 32'(level), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("show_led", 32'(led), (i < 4) ? oh(seqm[0]) : 32'd0);
        end
        @(negedge clk);
        press(seqm[0], 1'b1);
        good(1);
        repeat (3) @(negedge clk);
        start = 1'b1;             // must be ignored mid-show
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        press(seqm[0], 1'b0);
        press(seqm[1], 1'b1);
        good(2);
        show(3);
        press(seqm[0], 1'b0);
        press(seqm[1], 1'b0);
        press(seqm[2], 1'b1);
        good(3);
        for (int i = 0; i < 50; i++) begin
            check("win_disp", 32'(disp_code), 32'd254);
            check("win_flag", 32'(game_won), 32'd1);
            @(negedge clk);
        end

        // wrong button at level 2, idx 1
        do_start();
        check("restart_won", 32'(game_won), 32'd0);
        show(1);
        press(seqm[0], 1'b1);
        good(1);
        show(2);
        press(seqm[0], 1'b0);
        w = seqm[1] + 2'd1;
        exp_disp.push_back(32'd253);
        btn = 4'(oh(w));
        @(negedge clk);
        btn = 4'b0;
        check("wrong_over", 32'(game_over), 32'd1);
        check("wrong_disp", 32'(disp_code), 32'd253);
        check("end_led", 32'(led), 32'd0);
        repeat (3) @(negedge clk);
        do_start();
        check("restart_level", 32'(level), 32'd1);
        check("restart_over", 32'(game_over), 32'd0);

        // held button counts once, then two rising together ends the game
        show(1);
        press(seqm[0], 1'b1);
        good(1);
        show(2);
        btn = 4'(oh(seqm[0]));
        repeat (HOLD) @(negedge clk);
        check("hold_disp", 32'(disp_code), 32'd2);
        check("hold_over", 32'(game_over), 32'd0);
        btn = 4'b0;
        @(negedge clk);
        press(seqm[1], 1'b1);
        good(2);
        show(3);
        w = seqm[0] + 2'd1;
        exp_disp.push_back(32'd253);
        btn = 4'(oh(seqm[0]) | oh(w));
        @(negedge clk);
        btn = 4'b0;
        check("double_over", 32'(game_over), 32'd1);

        // reset in SHOW_ON
        repeat (2) @(negedge clk);
        do_start();
        exp_disp.push_back(32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_disp", 32'(disp_code), 32'd0);
        check("midrst_over", 32'(game_over), 32'd0);
        check("midrst_won", 32'(game_won), 32'd0);

        // idle input phase
        @(negedge clk);
        do_start();
        show(1);
`ifdef INPUT_TIMEOUT_EN
        exp_disp.push_back(32'd253);
        repeat (19) @(negedge clk);
        check("to_before", 32'(game_over), 32'd0);
        @(negedge clk);
        check("to_after", 32'(game_over), 32'd1);
`else
        repeat (40) @(negedge clk);
        check("wait_over", 32'(game_over), 32'd0);
        check("wait_disp", 32'(disp_code), 32'd1);
`endif
        repeat (3) @(negedge clk);
        check("led_q_empty", 32'(exp_led.size()), 32'd0);
        check("disp_q_empty", 32'(exp_disp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
